serial_rx: RTL and testbench
============================

// Module: serial_rx
// PURPOSE
//  Receiving end of the gpp_txrx serial link: recovers frames from the single-bit line driven by the
//  link transmitter and deserialises them into WIDTH-bit words. Line is idle-high. Frame format:
//  start(0), WIDTH data bits LSB first, [parity], stop(1). Each received word is held in a one-entry
//  output register and handed to the core with a valid/ready handshake.
// PARAMETERS
//  WIDTH         8   data bits per frame (1..32)
//  CLKS_PER_BIT  16  clk cycles per bit period (>=4, even)
// PORTS
//  clk         in   1      clock, all logic on posedge
//  rst         in   1      asynchronous, active-low reset (asserted when 0)
//  rx_in       in   1      serial line, asynchronous to clk
//  rx_data     out  WIDTH  received word, stable while rx_valid=1
//  rx_valid    out  1      rx_data holds an unconsumed word
//  rx_ready    in   1      consumer accepts rx_data on a cycle with rx_valid=1 and rx_ready=1
//  frame_err   out  1      1-cycle pulse: stop bit sampled 0
//  parity_err  out  1      1-cycle pulse: parity mismatch (tied 0 without RX_PARITY_EN)
//  overrun     out  1      1-cycle pulse: good frame dropped because the holding register was full
//  busy        out  1      1 whenever the FSM is not in IDLE
// BEHAVIOUR
//  - Reset (rst=0, async): FSM=IDLE, counters=0, synchroniser flops=1, all outputs 0.
//  - rx_in passes a 2-flop synchroniser (reset value 1); all decisions use the synchronised bit.
//  - Bit counter cnt runs 0..CLKS_PER_BIT-1; a sample point is cnt==CLKS_PER_BIT-1 after the half-bit alignment.
//  - IDLE: synchronised line 0 -> START, cnt=0.
//  - START: at cnt==CLKS_PER_BIT/2-1 sample; 0 -> DATA (cnt=0, bit_idx=0); 1 -> IDLE (glitch rejected, no error).
//  - DATA: at each sample point shift the bit into shreg (LSB first), bit_idx++; after bit WIDTH-1 -> PARITY
//    (with RX_PARITY_EN) else STOP.
//  - STOP: at sample point: 1 -> frame good, IDLE; 0 -> frame_err pulse, word discarded, -> WAIT_HIGH.
//  - WAIT_HIGH: stay until synchronised line 1, then IDLE (a held-low line never re-triggers a frame).
//  - Good frame completion (cycle after STOP sample point):
//      rx_valid=0, or rx_valid=1 and rx_ready=1 same cycle -> rx_data<=shreg, rx_valid=1;
//      rx_valid=1 and rx_ready=0 -> overrun pulse, old word kept, new word dropped.
//  - Handshake: rx_valid=1 and rx_ready=1 with no completion -> rx_valid<=0 next cycle; rx_data unchanged.
//    rx_ready with rx_valid=0 is ignored.
//  - Latency: rx_valid rises 1 cycle after the stop-bit sample point (~WIDTH+1.5 bit periods + 2 sync
//    cycles after the start-bit falling edge).
//  - Error pulses never set rx_valid. Reset mid-frame aborts the frame; no pulses are produced.
//  - Frames may be back-to-back: a new start edge is accepted the cycle after returning to IDLE.
// CONFIGURATION
//  RX_PARITY_EN defined: PARITY state after DATA; the bit is sampled at its sample point; even parity
//    over data+parity. Mismatch -> parity_err pulse, word discarded, FSM still checks the stop bit
//    (if the stop bit is also 0, frame_err pulses too, same cycle).
//  RX_PARITY_EN undefined: no PARITY state, frame = 10 bits at WIDTH=8, parity_err tied 0.
// STRUCTURE
//  - serial_pkg: rx_state_t enum {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH}; LINE_IDLE=1'b1,
//    START_BIT=1'b0 constants, shared with the link transmitter.
//  - One sub-module: sync_2ff (2-flop synchroniser, async active-low reset, reset value parameter).
//  - Everything else in one always_ff (FSM, counters, shreg, output register) + comb next-state.
// TESTING  (WIDTH=8, CLKS_PER_BIT=16)
//  1. Send 0xA5, rx_ready=1 -> one rx_valid pulse with rx_data=0xA5; no error pulses.
//  2. Send 0x3C then 0xC3 back-to-back with rx_ready=0 -> rx_data=0x3C held, overrun pulse once, then
//     ready=1 -> rx_valid falls, data=0x3C consumed.
//  3. Drive rx_in low for 4 cycles then high -> FSM returns to IDLE, busy low, no outputs change.
//  4. Send 0x55 with stop bit=0, keep line low 40 cycles -> frame_err pulse, rx_valid stays 0, no
//     new frame until line high; following 0x0F received correctly.
//  5. Pull rst low in the middle of the data bits of 0xFF -> all outputs 0 immediately; next 0x81 received cleanly.
//  6. RX_PARITY_EN: send 0x07 with parity bit 0 -> parity_err pulse, no rx_valid; with parity 1 -> rx_data=0x07.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared serial link definitions: receiver state encoding and line levels used by both link ends.
package serial_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_HIGH = 3'd5
    } rx_state_t;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous bit; 2-cycle latency, no backpressure.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/serial_rx.sv
// Serial link receiver: start/data/[parity]/stop frames into a one-entry valid/ready holding register.
// rx_valid rises 1 cycle after the stop-bit sample; a full register drops new good words with an overrun pulse.
// Optional even-parity checking is compiled in with RX_PARITY_EN.
module serial_rx
    import serial_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx_in,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic             frame_err,
    output logic             parity_err,
    output logic             overrun,
    output logic             busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(WIDTH) + 1;

    logic             rx_s;
    rx_state_t        state;
    rx_state_t        state_nxt;
    logic [CW-1:0]    cnt;
    logic [IW-1:0]    bit_idx;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_nxt;
    logic [WIDTH:0]   shift_w;
    logic             sample;
    logic             half;
    logic             last_bit;
    logic             good;
    logic             par_bad;

    sync_2ff #(.RST_VAL(LINE_IDLE)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx_in),
        .q   (rx_s)
    );

`ifdef RX_PARITY_EN
    logic par_err_q;
    assign parity_err = par_err_q;
`else
    assign par_bad    = 1'b0;
    assign parity_err = 1'b0;
`endif

    assign sample    = (cnt == CW'(CLKS_PER_BIT - 1));
    assign half      = (cnt == CW'(CLKS_PER_BIT / 2 - 1));
    assign last_bit  = (bit_idx == IW'(WIDTH - 1));
    // New bits enter at the MSB so the first (LSB) bit ends up in bit 0.
    assign shift_w   = {rx_s, shreg};
    assign shreg_nxt = shift_w[WIDTH:1];
    assign good      = (state == STOP) && sample && (rx_s == LINE_IDLE) && !par_bad;
    assign busy      = (state != IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (rx_s == START_BIT) state_nxt = START;
            START:     if (half) state_nxt = (rx_s == START_BIT) ? DATA : IDLE;
            DATA: begin
                if (sample && last_bit) begin
`ifdef RX_PARITY_EN
                    state_nxt = PARITY;
`else
                    state_nxt = STOP;
`endif
                end
            end
            PARITY:    if (sample) state_nxt = STOP;
            STOP:      if (sample) state_nxt = (rx_s == LINE_IDLE) ? IDLE : WAIT_HIGH;
            WAIT_HIGH: if (rx_s == LINE_IDLE) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
`ifdef RX_PARITY_EN
            par_bad   <= 1'b0;
            par_err_q <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
`ifdef RX_PARITY_EN
            par_err_q <= 1'b0;
`endif

            if (state_nxt != state || sample || state == IDLE || state == WAIT_HIGH)
                cnt <= '0;
            else
                cnt <= cnt + 1'b1;

            if (state == START) begin
                bit_idx <= '0;
            end else if (state == DATA && sample) begin
                bit_idx <= bit_idx + 1'b1;
                shreg   <= shreg_nxt;
            end

`ifdef RX_PARITY_EN
            // Even parity: data plus parity bit must XOR to zero.
            if (state == START)
                par_bad <= 1'b0;
            else if (state == PARITY && sample)
                par_bad <= ^{shreg, rx_s};
`endif

            if (state == STOP && sample) begin
                if (rx_s != LINE_IDLE)
                    frame_err <= 1'b1;
`ifdef RX_PARITY_EN
                par_err_q <= par_bad;
`endif
            end

            if (good) begin
                if (!rx_valid || rx_ready) begin
                    rx_data  <= shreg;
                    rx_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_serial_rx.sv
// Self-checking bench for serial_rx: vector table, corner-case sequences and random frames vs a frame-level model.
module tb_serial_rx;

    localparam int W   = 8;
    localparam int CPB = 16;
`ifdef RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         rx_in;
    logic [W-1:0] rx_data;
    logic         rx_valid;
    logic         rx_ready;
    logic         frame_err;
    logic         parity_err;
    logic         overrun;
    logic         busy;

    serial_rx #(.WIDTH(W), .CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_in      (rx_in),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Output monitor: event counters sampled on the falling edge.
    int           cyc = 0;
    int           n_rise = 0, n_acc = 0, n_ferr = 0, n_perr = 0, n_ovr = 0;
    int           rise_cyc = 0;
    logic [W-1:0] last_rise = '0, last_acc = '0;
    logic         prev_v = 1'b0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rx_valid && !prev_v) begin
            n_rise++;
            last_rise = rx_data;
            rise_cyc  = cyc;
        end
        if (rx_valid && rx_ready) begin
            n_acc++;
            last_acc = rx_data;
        end
        if (frame_err)  n_ferr++;
        if (parity_err) n_perr++;
        if (overrun)    n_ovr++;
        prev_v = rx_valid;
    end

    int b_rise, b_acc, b_ferr, b_perr, b_ovr;

    task automatic snap();
        b_rise = n_rise; b_acc = n_acc; b_ferr = n_ferr; b_perr = n_perr; b_ovr = n_ovr;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        rx_in = b;
        tick(CPB);
    endtask

    // Start bit, data LSB first, and the parity bit when the build has one.
    task automatic send_body(input logic [W-1:0] d, input logic bad_par);
        send_bit(1'b0);
        for (int i = 0; i < W; i++) send_bit(d[i]);
        if (PAR_EN) send_bit((^d) ^ bad_par);
    endtask

    task automatic send_frame(input logic [W-1:0] d, input logic stop, input logic bad_par);
        send_body(d, bad_par);
        send_bit(stop);
        rx_in = 1'b1;
    endtask

    function automatic bit frame_good(input logic stop, input logic bad_par);
        return stop && !(PAR_EN && bad_par);
    endfunction

    typedef struct {
        logic [W-1:0] d;
        logic         stop;
        logic         rdy;
        int           words;
        logic [W-1:0] exp_d;
        int           ferr;
    } vec_t;

    vec_t tbl[6];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        rst      = 1'b0;
        rx_in    = 1'b1;
        rx_ready = 1'b0;
        tick(3);
        chk("reset_outputs", {rx_valid, busy, frame_err, parity_err, overrun, rx_data}, 0);
        rst = 1'b1;
        tick(4);

        // Test 1: 0xA5 with ready high, plus start-edge to rx_valid latency.
        snap();
        rx_ready = 1'b1;
        lat = cyc;
        send_frame(8'hA5, 1'b1, 1'b0);
        tick(CPB);
        chk("t1_words", n_rise - b_rise, 1);
        chk("t1_data", last_acc, 8'hA5);
        chk("t1_errs", (n_ferr - b_ferr) + (n_perr - b_perr) + (n_ovr - b_ovr), 0);
        lat = rise_cyc - lat;
        chk("t1_latency_in_window", (lat >= (W + 1) * CPB + CPB / 2 - 2 && lat <= (W + 1) * CPB + CPB / 2 + 6), 1);

        // Vector table.
        tbl[0] = '{8'hA5, 1'b1, 1'b1, 1, 8'hA5, 0};
        tbl[1] = '{8'h00, 1'b1, 1'b1, 1, 8'h00, 0};
        tbl[2] = '{8'hFF, 1'b1, 1'b1, 1, 8'hFF, 0};
        tbl[3] = '{8'h55, 1'b0, 1'b1, 0, 8'h00, 1};
        tbl[4] = '{8'h0F, 1'b1, 1'b0, 1, 8'h0F, 0};
        tbl[5] = '{8'h81, 1'b1, 1'b1, 1, 8'h81, 0};
        foreach (tbl[k]) begin
            snap();
            rx_ready = tbl[k].rdy;
            send_frame(tbl[k].d, tbl[k].stop, 1'b0);
            tick(CPB);
            chk($sformatf("vec%0d_words", k), n_rise - b_rise, tbl[k].words);
            if (tbl[k].words > 0) chk($sformatf("vec%0d_data", k), last_rise, tbl[k].exp_d);
            chk($sformatf("vec%0d_ferr", k), n_ferr - b_ferr, tbl[k].ferr);
            chk($sformatf("vec%0d_ovr", k), n_ovr - b_ovr, 0);
            rx_ready = 1'b1;
            tick(2);
            chk($sformatf("vec%0d_drained", k), rx_valid, 0);
        end

        // Test 2: two back-to-back words with ready low.
        snap();
        rx_ready = 1'b0;
        send_frame(8'h3C, 1'b1, 1'b0);
        send_frame(8'hC3, 1'b1, 1'b0);
        tick(CPB);
        chk("t2_valid_held", rx_valid, 1);
        chk("t2_data_held", rx_data, 8'h3C);
        chk("t2_overrun", n_ovr - b_ovr, 1);
        chk("t2_rises", n_rise - b_rise, 1);
        rx_ready = 1'b1;
        tick(1);
        chk("t2_valid_fall", rx_valid, 0);
        chk("t2_data_after", rx_data, 8'h3C);
        chk("t2_accepts", n_acc - b_acc, 1);
        chk("t2_acc_data", last_acc, 8'h3C);

        // Test 3: short low glitch is rejected silently.
        snap();
        rx_in = 1'b0;
        tick(4);
        rx_in = 1'b1;
        tick(2);
        chk("t3_busy_during", busy, 1);
        tick(20);
        chk("t3_busy_after", busy, 0);
        chk("t3_no_events", (n_rise - b_rise) + (n_ferr - b_ferr) + (n_ovr - b_ovr), 0);

        // Test 4: bad stop bit with the line held low afterwards.
        snap();
        send_body(8'h55, 1'b0);
        rx_in = 1'b0;
        tick(CPB + 40);
        chk("t4_ferr", n_ferr - b_ferr, 1);
        chk("t4_no_valid", n_rise - b_rise, 0);
        chk("t4_busy_held_low", busy, 1);
        rx_in = 1'b1;
        tick(CPB);
        chk("t4_idle_after_high", busy, 0);
        send_frame(8'h0F, 1'b1, 1'b0);
        tick(CPB);
        chk("t4_next_words", n_rise - b_rise, 1);
        chk("t4_next_data", last_rise, 8'h0F);
        chk("t4_ferr_total", n_ferr - b_ferr, 1);

        // Test 5: reset in the middle of a frame.
        rx_ready = 1'b0;
        send_frame(8'h42, 1'b1, 1'b0);
        tick(CPB);
        chk("t5_pre_valid", rx_valid, 1);
        snap();
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        rst = 1'b0;
        #1;
        chk("t5_reset_outputs", {rx_valid, busy, frame_err, parity_err, overrun, rx_data}, 0);
        rx_in = 1'b1;
        tick(5);
        rst = 1'b1;
        tick(CPB);
        rx_ready = 1'b1;
        send_frame(8'h81, 1'b1, 1'b0);
        tick(CPB);
        chk("t5_next_words", n_rise - b_rise, 1);
        chk("t5_next_data", last_rise, 8'h81);
        chk("t5_no_pulses", (n_ferr - b_ferr) + (n_perr - b_perr) + (n_ovr - b_ovr), 0);

`ifdef RX_PARITY_EN
        // Test 6: parity mismatch, then correct parity, then both errors together.
        snap();
        send_frame(8'h07, 1'b1, 1'b1);
        tick(CPB);
        chk("t6_perr", n_perr - b_perr, 1);
        chk("t6_no_valid", n_rise - b_rise, 0);
        snap();
        send_frame(8'h07, 1'b1, 1'b0);
        tick(CPB);
        chk("t6_good_words", n_rise - b_rise, 1);
        chk("t6_good_data", last_rise, 8'h07);
        chk("t6_good_perr", n_perr - b_perr, 0);
        snap();
        send_frame(8'h07, 1'b0, 1'b1);
        tick(CPB);
        chk("t6_both_perr", n_perr - b_perr, 1);
        chk("t6_both_ferr", n_ferr - b_ferr, 1);
`endif

        // Random frames against the frame-level model.
        rx_ready = 1'b1;
        for (int f = 0; f < 24; f++) begin
            logic [W-1:0] d;
            logic         stop;
            logic         bad_par;
            int           gap;
            d       = W'($urandom);
            stop    = ($urandom_range(0, 3) != 0);
            bad_par = ($urandom_range(0, 3) == 0);
            gap     = $urandom_range(0, CPB);
            if (!stop) gap += CPB;
            snap();
            send_frame(d, stop, bad_par);
            chk($sformatf("rnd%0d_words", f), n_rise - b_rise, frame_good(stop, bad_par));
            if (frame_good(stop, bad_par)) chk($sformatf("rnd%0d_data", f), last_rise, d);
            chk($sformatf("rnd%0d_ferr", f), n_ferr - b_ferr, !stop);
            chk($sformatf("rnd%0d_perr", f), n_perr - b_perr, PAR_EN && bad_par);
            if (gap > 0) tick(gap);
        end
        tick(CPB);
        chk("rnd_no_overrun", n_ovr, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
